// File: rtl/ordenator_unloader_if.sv
// Output stream bundle of the ordenator unloader: element, index, last marker and valid/ready.
interface ordenator_unloader_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DATA_SIZE  = 9,
    parameter int unsigned IDX_W      = (($clog2(DATA_SIZE) > 0) ? $clog2(DATA_SIZE) : 1)
);
    logic [DATA_WIDTH-1:0] dout_o;
    logic                  dout_valid_o;
    logic                  dout_ready_i;
    logic [IDX_W-1:0]      dout_idx_o;
    logic                  dout_last_o;

    modport master (
        output dout_o,
        output dout_valid_o,
        output dout_idx_o,
        output dout_last_o,
        input  dout_ready_i
    );

    modport slave (
        input  dout_o,
        input  dout_valid_o,
        input  dout_idx_o,
        input  dout_last_o,
        output dout_ready_i
    );
endinterface

// File: rtl/ordenator_unloader.sv
// Captures the sorter result on each sort_done rise, streams it out index 0 first,
// and flags any out-of-order element or a new result arriving mid-stream.
module ordenator_unloader #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DATA_SIZE  = 9,
    parameter int unsigned IDX_W      = (($clog2(DATA_SIZE) > 0) ? $clog2(DATA_SIZE) : 1)
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic [DATA_WIDTH-1:0] numbers_i [DATA_SIZE],
    input  logic                  sort_done_i,
    input  logic                  clr_i,
    ordenator_unloader_if.master  dout,
    output logic                  busy_o,
    output logic                  order_err_o,
    output logic                  overrun_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_SIZE - 1);

    typedef enum logic {IDLE, STREAM} state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] buf_q [DATA_SIZE];
    logic [DATA_WIDTH-1:0] buf_d [DATA_SIZE];
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] prev_q, prev_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  valid_q, valid_d;
    logic                  last_q, last_d;
    logic                  busy_q, busy_d;
    logic                  err_q, err_d;
    logic                  ovr_q, ovr_d;
    logic                  sort_done_q, sort_done_d;

    logic                  start_c;
    logic                  xfer_c;
    logic                  at_last_c;
    logic [IDX_W-1:0]      idx_inc_c;

    assign sort_done_d = sort_done_i;
    assign start_c     = sort_done_i & ~sort_done_q;
    assign xfer_c      = valid_q & dout.dout_ready_i;
    assign at_last_c   = (idx_q == LAST_IDX);
    assign idx_inc_c   = idx_q + IDX_W'(1);

    // State register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_c)              state_d = STREAM;
            STREAM:  if (xfer_c && at_last_c)  state_d = IDLE;
            default:                           state_d = IDLE;
        endcase
    end

    // Datapath and registered-output next values; a set condition overrides clr_i
    always_comb begin
        buf_d   = buf_q;
        idx_d   = idx_q;
        prev_d  = prev_q;
        dout_d  = dout_q;
        valid_d = valid_q;
        last_d  = last_q;
        busy_d  = busy_q;
        err_d   = err_q;
        ovr_d   = ovr_q;

        if (clr_i) begin
            err_d = 1'b0;
            ovr_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start_c) begin
                    buf_d   = numbers_i;
                    idx_d   = '0;
                    dout_d  = numbers_i[0];
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    last_d  = 1'b0;
                end
            end
            STREAM: begin
                if (start_c) begin
                    ovr_d = 1'b1;
                end
                if (xfer_c) begin
                    prev_d = buf_q[idx_q];
                    if ((idx_q != '0) && (buf_q[idx_q] < prev_q)) begin
                        err_d = 1'b1;
                    end
                    if (at_last_c) begin
                        idx_d   = '0;
                        dout_d  = '0;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        last_d  = 1'b0;
                    end else begin
                        idx_d  = idx_inc_c;
                        dout_d = buf_q[idx_inc_c];
                        last_d = (idx_inc_c == LAST_IDX);
                    end
                end
            end
            default: ;
        endcase
    end

    // Data and output registers
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < int'(DATA_SIZE); i++) begin
                buf_q[i] <= '0;
            end
            idx_q       <= '0;
            prev_q      <= '0;
            dout_q      <= '0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            ovr_q       <= 1'b0;
            sort_done_q <= 1'b0;
        end else begin
            buf_q       <= buf_d;
            idx_q       <= idx_d;
            prev_q      <= prev_d;
            dout_q      <= dout_d;
            valid_q     <= valid_d;
            last_q      <= last_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            ovr_q       <= ovr_d;
            sort_done_q <= sort_done_d;
        end
    end

    assign dout.dout_o       = dout_q;
    assign dout.dout_valid_o = valid_q;
    assign dout.dout_idx_o   = idx_q;
    assign dout.dout_last_o  = last_q;
    assign busy_o            = busy_q;
    assign order_err_o       = err_q;
    assign overrun_o         = ovr_q;

endmodule

// File: doc/ordenator_unloader.md
Name: ordenator_unloader

Overview:
- Reader on the output side of the ordenator sorter.
- On each completed sort it captures the full parallel result array, then streams the elements out one per transfer, index 0 first, over a valid/ready handshake.
- While streaming it checks that the elements are in non-decreasing order and flags any violation, giving a hardware self-check of the sorter result.

Parameters:
- DATA_WIDTH, 8, bits per element.
- DATA_SIZE, 9, elements per sorted array; legal range ≥2.
- IDX_W, ($clog2(DATA_SIZE) > 0 ? $clog2(DATA_SIZE) : 1), width of the index output.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rstn_i  in  1  reset, asynchronous, active-low.
- numbers_i  in  DATA_WIDTH x DATA_SIZE (unpacked array)  sorted array from the sorter (its numbers_o).
- sort_done_i  in  1  sorter ready; array valid while high.
- clr_i  in  1  synchronous clear of the sticky flags.
- dout_o  out  DATA_WIDTH  current element.
- dout_valid_o  out  1  dout_o valid.
- dout_ready_i  in  1  downstream accepts.
- dout_idx_o  out  IDX_W  index of the current element.
- dout_last_o  out  1  current element is index DATA_SIZE-1.
- busy_o  out  1  array held / streaming.
- order_err_o  out  1  sticky: element smaller than its predecessor was sent.
- overrun_o  out  1  sticky: new sort_done edge while busy.

Behaviour:
- Reset (async assert, sync release) sets:
  - state=IDLE; capture buffer to 0;
  - dout_o=0, dout_valid_o=0, dout_idx_o=0, dout_last_o=0;
  - busy_o=0, order_err_o=0, overrun_o=0;
  - sort_done_q=0, prev element=0.
- Edge detect: sort_done_q registers sort_done_i. start = sort_done_i & ~sort_done_q. A level held high produces exactly one capture.
- States: IDLE, STREAM.
- IDLE, start=1 at edge N:
  - buffer <= numbers_i, captured at edge N;
  - idx <= 0; state -> STREAM.
  - From edge N: busy_o=1, dout_valid_o=1, dout_o=buffer[0].
  - Latency is 1 cycle from the sort_done_i rise to valid.
- STREAM:
  - dout_o = buffer[idx]; dout_idx_o = idx; dout_last_o = (idx==DATA_SIZE-1).
  - A transfer occurs on an edge where dout_valid_o & dout_ready_i.
  - When dout_valid_o=1 and dout_ready_i=0, dout_o, dout_idx_o and dout_last_o hold stable.
  - On a transfer with idx<DATA_SIZE-1: idx <= idx+1.
  - On a transfer with idx==DATA_SIZE-1: state -> IDLE, dout_valid_o=0, busy_o=0, dout_idx_o=0, next cycle.
  - Back-to-back: a start in the same cycle as the last transfer is treated as overrun, not captured. IDLE is required for capture.
- Order check, on every transfer with idx>0: if buffer[idx] < prev, order_err_o <= 1. Then prev <= buffer[idx].
  - Comparison is unsigned, DATA_WIDTH bits.
  - Equal values are legal.
  - idx 0 is never flagged.
- Overrun: start while state==STREAM sets overrun_o=1. The new array is dropped and the current stream continues undisturbed.
- clr_i=1 clears order_err_o and overrun_o at the next edge.
  - If clr_i and a new set condition occur in the same cycle, set wins.
  - clr_i does not affect the stream.
- Reset mid-stream: outputs return to reset values immediately (async). The stream is abandoned and no resumption occurs after release.
- The buffer is not modified during STREAM; numbers_i changes have no effect after capture.

Test Plan:
- DATA_WIDTH=8, DATA_SIZE=9 for all scenarios.
1. Basic: numbers_i={3,7,7,12,40,41,99,200,255}, sort_done_i rises, dout_ready_i=1 constant -> valid 1 cycle after rise. Nine consecutive transfers of the values in order, idx 0..8, last_o only with 255. busy_o low the cycle after. order_err_o=0.
2. Backpressure: same array, dout_ready_i toggles 1,0,0,1,... -> dout_o/idx held during low cycles. Exactly 9 transfers with no duplicates or skips.
3. Order error: numbers_i={1,2,3,9,5,6,7,8,10} -> order_err_o rises on the edge transferring idx 4 (value 5) and remains 1. clr_i pulse afterwards -> 0.
4. Overrun: sort_done_i rises, falls, and rises again at stream idx 3 with a different array -> overrun_o=1. Output still completes the first array. A later IDLE rise captures a new array normally.
5. Held level: sort_done_i held high for 30 cycles with dout_ready_i=1 -> exactly one stream of 9 transfers, overrun_o=0.
6. Reset mid-stream: rstn_i low at idx 5 -> dout_valid_o, busy_o and the flags go to 0 immediately. After release with no new edge, no output occurs.
